// File: rtl/match_ctl.sv
// ---------------------------------------------------------------------------
// match_ctl -- game-flow controller sitting downstream of the ball controller.
//
// Watches the two 4-bit player scores for goals and sequences the match
// through IDLE / PLAY / GOAL_PAUSE / GAME_OVER. Drives the motion freeze,
// a one-cycle game_rst strobe that restarts ball and score logic, and the
// status signals used by the display/overlay stages. Pause timing is
// counted in video frames (frame_tick).
//
// Optional build macro: AUTO_RESTART_EN
//   defined   : GAME_OVER times out after OVER_FRAMES frames and drops back
//               to IDLE on its own (no game_rst strobe).
//   undefined : GAME_OVER is held until a start edge; no timeout logic.
// ---------------------------------------------------------------------------
module match_ctl #(
    parameter int unsigned WIN_SCORE         = 7,
    parameter int unsigned GOAL_PAUSE_FRAMES = 120,
    parameter int unsigned FLASH_PERIOD      = 15,
    parameter int unsigned OVER_FRAMES       = 600
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [3:0] player_1_score,
    input  logic [3:0] player_2_score,
    output logic       game_rst,
    output logic       freeze,
    output logic [1:0] state,
    output logic [1:0] winner,
    output logic [1:0] goal_side,
    output logic       goal_flash
);

    // -----------------------------------------------------------------------
    // Sizing: one frame counter shared by GOAL_PAUSE and GAME_OVER, wide
    // enough for the largest frame count plus one spare bit.
    // -----------------------------------------------------------------------
    localparam int unsigned MAX_A      = (GOAL_PAUSE_FRAMES > FLASH_PERIOD) ?
                                         GOAL_PAUSE_FRAMES : FLASH_PERIOD;
    localparam int unsigned MAX_FRAMES = (MAX_A > OVER_FRAMES) ? MAX_A : OVER_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES) + 1;
    localparam int unsigned FLASH_W    = $clog2(FLASH_PERIOD) + 1;

    localparam logic [CNT_W-1:0]   CNT_SAT    = '1;
    localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(GOAL_PAUSE_FRAMES);
`ifdef AUTO_RESTART_EN
    localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_FRAMES);
`endif
    localparam logic [FLASH_W-1:0] FLASH_SAT  = '1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_PERIOD);
    localparam logic [3:0]         WIN_LEVEL  = 4'(WIN_SCORE);

    // Player identifiers shared by winner and goal_side.
    localparam logic [1:0] SIDE_NONE = 2'd0;
    localparam logic [1:0] SIDE_P1   = 2'd1;
    localparam logic [1:0] SIDE_P2   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GOAL_PAUSE = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_e             state_q;
    logic               freeze_q;
    logic               game_rst_q;
    logic [1:0]         winner_q;
    logic [1:0]         goal_side_q;
    logic               goal_flash_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [FLASH_W-1:0] flash_cnt_q;
    logic [3:0]         prev_score_1_q;
    logic [3:0]         prev_score_2_q;
    logic               start_prev_q;

    // Combinational helpers
    logic               start_edge;
    logic               goal_1;
    logic               goal_2;
    logic [CNT_W-1:0]   frame_cnt_d;
    logic [FLASH_W-1:0] flash_cnt_d;

    // Edge/goal detection and saturating counter increments.
    always_comb begin
        // NOTE: every always_comb output is assigned on every path so no latch is inferred.
        start_edge  = start_btn & ~start_prev_q;
        goal_1      = player_1_score > prev_score_1_q;
        goal_2      = player_2_score > prev_score_2_q;
        frame_cnt_d = (frame_cnt_q == CNT_SAT)   ? frame_cnt_q : frame_cnt_q + CNT_W'(1);
        flash_cnt_d = (flash_cnt_q == FLASH_SAT) ? flash_cnt_q : flash_cnt_q + FLASH_W'(1);
    end

    // Input history: previous scores and start level, tracked in every state.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            prev_score_1_q <= 4'd0;
            prev_score_2_q <= 4'd0;
            start_prev_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            prev_score_1_q <= player_1_score;
            prev_score_2_q <= player_2_score;
            start_prev_q   <= start_btn;
        end
    end

    // Game-flow FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            freeze_q     <= 1'b1;
            game_rst_q   <= 1'b0;
            winner_q     <= SIDE_NONE;
            goal_side_q  <= SIDE_NONE;
            goal_flash_q <= 1'b0;
            frame_cnt_q  <= '0;
            flash_cnt_q  <= '0;
        end else begin
            // game_rst is a strobe: low unless a restart is taken this cycle.
            game_rst_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    freeze_q     <= 1'b1;
                    goal_flash_q <= 1'b0;
                    if (start_edge) begin
                        game_rst_q  <= 1'b1;
                        winner_q    <= SIDE_NONE;
                        goal_side_q <= SIDE_NONE;
                        freeze_q    <= 1'b0;
                        state_q     <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    freeze_q     <= 1'b0;
                    goal_flash_q <= 1'b0;
                    // Player 1 is tested first so it wins a same-cycle tie.
                    if (goal_1) begin
                        freeze_q    <= 1'b1;
                        frame_cnt_q <= '0;
                        if (player_1_score >= WIN_LEVEL) begin
                            winner_q <= SIDE_P1;
                            state_q  <= ST_GAME_OVER;
                        end else begin
                            goal_side_q  <= SIDE_P1;
                            goal_flash_q <= 1'b1;
                            flash_cnt_q  <= '0;
                            state_q      <= ST_GOAL_PAUSE;
                        end
                    end else if (goal_2) begin
                        freeze_q    <= 1'b1;
                        frame_cnt_q <= '0;
                        if (player_2_score >= WIN_LEVEL) begin
                            winner_q <= SIDE_P2;
                            state_q  <= ST_GAME_OVER;
                        end else begin
                            goal_side_q  <= SIDE_P2;
                            goal_flash_q <= 1'b1;
                            flash_cnt_q  <= '0;
                            state_q      <= ST_GOAL_PAUSE;
                        end
                    end
                end

                ST_GOAL_PAUSE: begin
                    freeze_q <= 1'b1;
                    if (frame_tick) begin
                        if (frame_cnt_d == PAUSE_LAST) begin
                            // Pause complete; scores stay, the ball re-centres itself.
                            frame_cnt_q  <= '0;
                            flash_cnt_q  <= '0;
                            goal_flash_q <= 1'b0;
                            freeze_q     <= 1'b0;
                            state_q      <= ST_PLAY;
                        end else begin
                            frame_cnt_q <= frame_cnt_d;
                            if (flash_cnt_d == FLASH_LAST) begin
                                flash_cnt_q  <= '0;
                                goal_flash_q <= ~goal_flash_q;
                            end else begin
                                flash_cnt_q <= flash_cnt_d;
                            end
                        end
                    end
                end

                ST_GAME_OVER: begin
                    freeze_q     <= 1'b1;
                    goal_flash_q <= 1'b0;
                    // A start edge wins over a frame_tick in the same cycle.
                    if (start_edge) begin
                        game_rst_q  <= 1'b1;
                        winner_q    <= SIDE_NONE;
                        goal_side_q <= SIDE_NONE;
                        frame_cnt_q <= '0;
                        freeze_q    <= 1'b0;
                        state_q     <= ST_PLAY;
                    end
`ifdef AUTO_RESTART_EN
                    else if (frame_tick) begin
                        if (frame_cnt_d == OVER_LAST) begin
                            // Timeout back to attract mode, without restarting the ball logic.
                            frame_cnt_q <= '0;
                            winner_q    <= SIDE_NONE;
                            goal_side_q <= SIDE_NONE;
                            state_q     <= ST_IDLE;
                        end else begin
                            frame_cnt_q <= frame_cnt_d;
                        end
                    end
`endif
                end

                default: begin
                    state_q  <= ST_IDLE;
                    freeze_q <= 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs straight from registers
    // -----------------------------------------------------------------------
    assign game_rst   = game_rst_q;
    assign freeze     = freeze_q;
    assign state      = state_q;
    assign winner     = winner_q;
    assign goal_side  = goal_side_q;
    assign goal_flash = goal_flash_q;

endmodule

// File: tb/tb_match_ctl.sv
// ---------------------------------------------------------------------------
// tb_match_ctl -- self-checking bench for match_ctl.
// The bench plays the ball controller: it drives the scores and clears them
// after a game_rst strobe. A behavioural model tracks the match at the level
// of "current phase / ticks spent in it" and predicts every output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_match_ctl;

    localparam int WIN = 7;
    localparam int GPF = 120;
    localparam int FP  = 15;
    localparam int OF  = 600;

`ifdef AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSE = 2, S_OVER = 3;
    localparam logic [8:0] RESET_VEC = 9'b0_1_00_00_00_0;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic [3:0] player_1_score = 4'd0;
    logic [3:0] player_2_score = 4'd0;
    logic       game_rst, freeze, goal_flash;
    logic [1:0] state, winner, goal_side;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_state, m_winner, m_goal_side, m_pause_ticks, m_over_ticks;
    int m_prev1, m_prev2;
    bit m_game_rst, m_start_prev;

    match_ctl #(
        .WIN_SCORE(WIN), .GOAL_PAUSE_FRAMES(GPF), .FLASH_PERIOD(FP), .OVER_FRAMES(OF)
    ) dut (
        .clk_in(clk_in), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
        .player_1_score(player_1_score), .player_2_score(player_2_score),
        .game_rst(game_rst), .freeze(freeze), .state(state), .winner(winner),
        .goal_side(goal_side), .goal_flash(goal_flash)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] obs_vec();
        return {game_rst, freeze, state, winner, goal_side, goal_flash};
    endfunction

    // Expected outputs: freeze is "not playing", flash is the parity of
    // completed flash periods while paused.
    function automatic logic [8:0] exp_vec();
        bit fl;
        fl = (m_state == S_PAUSE) && (((m_pause_ticks / FP) % 2) == 0);
        return {m_game_rst, m_state != S_PLAY, 2'(m_state), 2'(m_winner), 2'(m_goal_side), fl};
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_winner = 0; m_goal_side = 0;
        m_pause_ticks = 0; m_over_ticks = 0;
        m_prev1 = 0; m_prev2 = 0; m_game_rst = 0; m_start_prev = 0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_clock();
        bit se, g1, g2;
        int s1, s2;
        s1 = int'(player_1_score);
        s2 = int'(player_2_score);
        se = start_btn && !m_start_prev;
        g1 = s1 > m_prev1;
        g2 = s2 > m_prev2;
        m_game_rst = 0;
        case (m_state)
            S_IDLE: if (se) begin
                m_game_rst = 1; m_goal_side = 0; m_winner = 0; m_state = S_PLAY;
            end
            S_PLAY: begin
                if (g1 || g2) begin
                    int who, sc;
                    who = g1 ? 1 : 2;
                    sc  = g1 ? s1 : s2;
                    if (sc >= WIN) begin
                        m_winner = who; m_over_ticks = 0; m_state = S_OVER;
                    end else begin
                        m_goal_side = who; m_pause_ticks = 0; m_state = S_PAUSE;
                    end
                end
            end
            S_PAUSE: if (frame_tick) begin
                m_pause_ticks++;
                if (m_pause_ticks == GPF) m_state = S_PLAY;
            end
            default: begin
                if (se) begin
                    m_game_rst = 1; m_winner = 0; m_goal_side = 0; m_state = S_PLAY;
                end else if (AUTO && frame_tick) begin
                    m_over_ticks++;
                    if (m_over_ticks == OF) begin
                        m_winner = 0; m_goal_side = 0; m_state = S_IDLE;
                    end
                end
            end
        endcase
        m_start_prev = start_btn;
        m_prev1 = s1;
        m_prev2 = s2;
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk_in);
        #1;
    endtask

    // Run a goal pause to completion with random tick spacing.
    task automatic run_pause(input string tag);
        int ticks, cyc;
        bit t;
        ticks = 0; cyc = 0;
        while (ticks < GPF && cyc < 20 * GPF) begin
            t = ($urandom_range(0, 3) != 0);
            frame_tick = t;
            cycle();
            frame_tick = 1'b0;
            cyc++;
            if (t) ticks++;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s_model: got %b expected %b (tick %0d)", tag, obs_vec(), exp_vec(), ticks);
            end
            if (t && ticks == FP - 1) begin
                n_tests++;
                if (goal_flash !== 1'b1) begin
                    n_fail++; $display("FAIL %s_flash_pre: got %b expected 1", tag, goal_flash);
                end
            end
            if (t && ticks == FP) begin
                n_tests++;
                if (goal_flash !== 1'b0) begin
                    n_fail++; $display("FAIL %s_flash_toggle: got %b expected 0", tag, goal_flash);
                end
            end
            if (t && ticks == GPF - 1) begin
                n_tests++;
                if (state !== 2'd2 || freeze !== 1'b1) begin
                    n_fail++; $display("FAIL %s_still_paused: state %0d freeze %b", tag, state, freeze);
                end
            end
            if (t && ticks == GPF) begin
                n_tests++;
                if (state !== 2'd1 || goal_flash !== 1'b0 || freeze !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_resume: state %0d flash %b freeze %b expected 1/0/0", tag, state, goal_flash, freeze);
                end
            end
        end
        n_tests++;
        if (ticks < GPF) begin
            n_fail++; $display("FAIL %s_timeout: only %0d of %0d ticks", tag, ticks, GPF);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        model_reset();
        n_tests++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_values: got %b expected %b", obs_vec(), RESET_VEC);
        end
        rst = 1'b0;
        cycle();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_start();
        start_btn = 1'b1;
        cycle();
        n_tests++;
        if (game_rst !== 1'b1 || state !== 2'd1 || freeze !== 1'b0) begin
            n_fail++;
            $display("FAIL start_pulse: game_rst %b state %0d freeze %b expected 1/1/0", game_rst, state, freeze);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_tests++;
            if (game_rst !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL start_hold: got %b expected %b", obs_vec(), exp_vec());
            end
        end
        start_btn = 1'b0;
        cycle();
    endtask

    task automatic test_goal_pause();
        player_2_score = 4'd2;
        cycle();
        n_tests++;
        if (state !== 2'd2 || goal_side !== 2'd2 || freeze !== 1'b1 || goal_flash !== 1'b1) begin
            n_fail++;
            $display("FAIL goal_p2_a: state %0d side %0d freeze %b flash %b", state, goal_side, freeze, goal_flash);
        end
        run_pause("pause_a");
        player_2_score = 4'd3;
        cycle();
        n_tests++;
        if (state !== 2'd2 || goal_side !== 2'd2 || freeze !== 1'b1 || goal_flash !== 1'b1) begin
            n_fail++;
            $display("FAIL goal_p2_b: state %0d side %0d freeze %b flash %b", state, goal_side, freeze, goal_flash);
        end
        run_pause("pause_b");
    endtask

    task automatic test_win_p1();
        player_1_score = 4'd6;
        cycle();
        n_tests++;
        if (state !== 2'd2 || goal_side !== 2'd1) begin
            n_fail++; $display("FAIL goal_p1: state %0d side %0d expected 2/1", state, goal_side);
        end
        run_pause("pause_c");
        player_1_score = 4'd7;
        cycle();
        n_tests++;
        if (state !== 2'd3 || winner !== 2'd1 || freeze !== 1'b1) begin
            n_fail++; $display("FAIL win_p1: state %0d winner %0d freeze %b expected 3/1/1", state, winner, freeze);
        end
        start_btn = 1'b1;
        cycle();
        n_tests++;
        if (game_rst !== 1'b1 || winner !== 2'd0 || goal_side !== 2'd0 || state !== 2'd1) begin
            n_fail++; $display("FAIL restart: got %b expected game_rst=1 state=1 winner=0", obs_vec());
        end
        // Ball controller clears the scores in response to game_rst.
        player_1_score = 4'd0;
        player_2_score = 4'd0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_tests++;
            if (state !== 2'd1 || game_rst !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL score_clear_no_goal: got %b expected %b", obs_vec(), exp_vec());
            end
        end
        start_btn = 1'b0;
        cycle();
    endtask

    task automatic test_both_win();
        player_1_score = 4'd6;
        player_2_score = 4'd6;
        cycle();
        n_tests++;
        if (state !== 2'd2 || goal_side !== 2'd1) begin
            n_fail++; $display("FAIL both_goal_priority: state %0d side %0d expected 2/1", state, goal_side);
        end
        run_pause("pause_d");
        player_1_score = 4'd7;
        player_2_score = 4'd7;
        cycle();
        n_tests++;
        if (state !== 2'd3 || winner !== 2'd1) begin
            n_fail++; $display("FAIL both_win: state %0d winner %0d expected 3/1", state, winner);
        end
        start_btn = 1'b1;
        cycle();
        player_1_score = 4'd0;
        player_2_score = 4'd0;
        start_btn = 1'b0;
        cycle();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL both_restart: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_over_timeout();
        int pulses;
        int exp_state, exp_winner;
        exp_state  = AUTO ? S_IDLE : S_OVER;
        exp_winner = AUTO ? 0 : 2;
        pulses = 0;
        player_2_score = 4'd7;
        cycle();
        n_tests++;
        if (state !== 2'd3 || winner !== 2'd2) begin
            n_fail++; $display("FAIL win_p2: state %0d winner %0d expected 3/2", state, winner);
        end
        for (int i = 1; i <= 1000; i++) begin
            frame_tick = 1'b1;
            cycle();
            if (game_rst === 1'b1) pulses++;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL over_model: got %b expected %b (tick %0d)", obs_vec(), exp_vec(), i);
            end
        end
        frame_tick = 1'b0;
        n_tests++;
        if (state !== 2'(exp_state) || winner !== 2'(exp_winner) || pulses != 0) begin
            n_fail++;
            $display("FAIL over_end: state %0d winner %0d pulses %0d expected %0d/%0d/0", state, winner, pulses, exp_state, exp_winner);
        end
        // Start edge coinciding with a frame tick.
        start_btn = 1'b1;
        frame_tick = 1'b1;
        cycle();
        n_tests++;
        if (game_rst !== 1'b1 || state !== 2'd1 || winner !== 2'd0) begin
            n_fail++; $display("FAIL start_with_tick: got %b expected game_rst=1 state=1", obs_vec());
        end
        frame_tick = 1'b0;
        start_btn = 1'b0;
        player_2_score = 4'd0;
        cycle();
    endtask

    task automatic test_async_reset();
        player_1_score = 4'd3;
        cycle();
        for (int i = 0; i < 50; i++) begin
            frame_tick = 1'b1;
            cycle();
        end
        frame_tick = 1'b0;
        n_tests++;
        if (state !== 2'd2) begin
            n_fail++; $display("FAIL pre_reset_pause: state %0d expected 2", state);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL async_reset: got %b expected %b", obs_vec(), RESET_VEC);
        end
        model_reset();
        player_1_score = 4'd0;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        cycle();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL after_reset: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            frame_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            if (m_game_rst) begin
                player_1_score = 4'd0;
                player_2_score = 4'd0;
            end else if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: if (player_1_score != 4'd15) player_1_score = player_1_score + 4'd1;
                    1: if (player_2_score != 4'd15) player_2_score = player_2_score + 4'd1;
                    2: begin
                        if (player_1_score != 4'd15) player_1_score = player_1_score + 4'd1;
                        if (player_2_score != 4'd15) player_2_score = player_2_score + 4'd1;
                    end
                    default: if (player_1_score != 4'd0) player_1_score = player_1_score - 4'd1;
                endcase
            end
            cycle();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
        end
        frame_tick = 1'b0;
        start_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_goal_pause();
        test_win_p1();
        test_both_win();
        test_over_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
